// File: rtl/multicycle_ctrl.sv
// Control FSM for a multicycle RISC-V datapath with a shared memory port.
// Sequences fetch/decode/execute/mem/write-back, counts retirements, traps.
//
// Ports:
//   clk, arst_n       clock and synchronous active-low reset
//   start, halt_req   leave IDLE / return to IDLE at the next retirement
//   opcode            instruction register [6:0]
//   mem_ready         shared memory finished its access this cycle
//   pc_write*, pc_source, ir_write, i_or_d,
//   mem_read, mem_write, mem_2_reg, reg_write,
//   alu_src_a, alu_src_b, alu_op   datapath strobes and mux selects
//   busy, trap, trap_cause, retired   status
module multicycle_ctrl #(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             start,
  input  logic             halt_req,
  input  logic [6:0]       opcode,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_c,
  output logic [1:0]       pc_source,
  output logic             ir_write,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             mem_2_reg,
  output logic             reg_write,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             busy,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] retired
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST =
    WAIT_W'(MEM_TIMEOUT - 1);

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;
  localparam logic [6:0] OP_J  = 7'b1101111;

  localparam logic [1:0] CAUSE_ILL = 2'b01;
  localparam logic [1:0] CAUSE_TMO = 2'b10;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC_R,
    S_EXEC_I,
    S_WB_ALU,
    S_ADDR,
    S_MEM_RD,
    S_WB_MEM,
    S_MEM_WR,
    S_BRANCH,
    S_JUMP,
    S_TRAP
  } state_t;

  state_t             state_q, state_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [CNT_W-1:0]   ret_q, ret_d;
  logic               trap_q, trap_d;
  logic [1:0]         cause_q, cause_d;

  // Next state. mem_wait handles the three memory-wait states alike:
  // ready advances, otherwise count, and the last allowed idle
  // cycle traps. A ready in that last cycle still wins.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    ret_d   = ret_q;
    trap_d  = trap_q;
    cause_d = cause_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH, S_MEM_RD, S_MEM_WR: begin
        if (mem_ready) begin
          wait_d = '0;
          unique case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_MEM_RD: state_d = S_WB_MEM;
            default: begin
              ret_d   = ret_q + CNT_W'(1);
              state_d = halt_req ? S_IDLE : S_FETCH;
            end
          endcase
        end else if (wait_q == WAIT_LAST) begin
          wait_d  = '0;
          state_d = S_TRAP;
          trap_d  = 1'b1;
          cause_d = CAUSE_TMO;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_DECODE: begin
        unique case (1'b1)
          (opcode == OP_R):  state_d = S_EXEC_R;
          (opcode == OP_I):  state_d = S_EXEC_I;
          (opcode == OP_LD),
          (opcode == OP_ST): state_d = S_ADDR;
          (opcode == OP_BR): state_d = S_BRANCH;
          (opcode == OP_J):  state_d = S_JUMP;
          default: begin
            state_d = S_TRAP;
            trap_d  = 1'b1;
            cause_d = CAUSE_ILL;
          end
        endcase
      end
      S_EXEC_R, S_EXEC_I: begin
        state_d = S_WB_ALU;
      end
      S_ADDR: begin
        state_d = (opcode == OP_LD) ? S_MEM_RD : S_MEM_WR;
      end
      S_WB_ALU, S_WB_MEM, S_BRANCH, S_JUMP: begin
        ret_d   = ret_q + CNT_W'(1);
        state_d = halt_req ? S_IDLE : S_FETCH;
      end
      S_TRAP: begin
        state_d = S_TRAP;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      state_q <= S_IDLE;
      wait_q  <= '0;
      ret_q   <= '0;
      trap_q  <= 1'b0;
      cause_q <= 2'b00;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      ret_q   <= ret_d;
      trap_q  <= trap_d;
      cause_q <= cause_d;
    end
  end

  // Datapath controls are a pure decode of the state register;
  // only the fetch-cycle IR/PC loads wait for mem_ready.
  always_comb begin
    pc_write   = 1'b0;
    pc_write_c = 1'b0;
    pc_source  = 2'b00;
    ir_write   = 1'b0;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_2_reg  = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;

    unique case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b10;
      end
      S_EXEC_R: begin
        alu_src_a = 2'b01;
        alu_op    = 2'b10;
      end
      S_EXEC_I, S_ADDR: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
      end
      S_WB_ALU: begin
        reg_write = 1'b1;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      S_WB_MEM: begin
        reg_write = 1'b1;
        mem_2_reg = 1'b1;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a  = 2'b01;
        alu_op     = 2'b01;
        pc_write_c = 1'b1;
        pc_source  = 2'b01;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b01;
      end
      default: begin
        pc_write = 1'b0;
      end
    endcase
  end

  assign busy       = (state_q != S_IDLE) && (state_q != S_TRAP);
  assign trap       = trap_q;
  assign trap_cause = cause_q;
  assign retired    = ret_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: vector table plus
// hand sequences for timeout and counter wrap.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       arst_n;
  logic       start;
  logic       halt_req;
  logic [6:0] opcode;
  logic       mem_ready;
  logic       pc_write, pc_write_c, ir_write, i_or_d;
  logic       mem_read, mem_write, mem_2_reg, reg_write;
  logic [1:0] pc_source, alu_src_a, alu_src_b, alu_op;
  logic       busy, trap;
  logic [1:0] trap_cause;
  logic [3:0] retired;

  always #5 clk = ~clk;

  multicycle_ctrl #(.CNT_W(4), .MEM_TIMEOUT(4)) dut (
    .clk(clk), .arst_n(arst_n), .start(start),
    .halt_req(halt_req), .opcode(opcode),
    .mem_ready(mem_ready), .pc_write(pc_write),
    .pc_write_c(pc_write_c), .pc_source(pc_source),
    .ir_write(ir_write), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_2_reg(mem_2_reg), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .busy(busy), .trap(trap),
    .trap_cause(trap_cause), .retired(retired)
  );

  // {pc_write,pc_write_c,pc_source,ir_write,i_or_d,mem_read,
  //  mem_write,mem_2_reg,reg_write,src_a,src_b,alu_op,busy,
  //  trap,trap_cause}
  logic [19:0] got;
  assign got = {pc_write, pc_write_c, pc_source, ir_write,
                i_or_d, mem_read, mem_write, mem_2_reg,
                reg_write, alu_src_a, alu_src_b, alu_op,
                busy, trap, trap_cause};

  localparam logic [19:0] O_IDLE = 20'b0;
  localparam logic [19:0] O_FW  = 20'b0_0_00_0_0_1_0_0_0_00_01_00_1_0_00;
  localparam logic [19:0] O_FR  = 20'b1_0_00_1_0_1_0_0_0_00_01_00_1_0_00;
  localparam logic [19:0] O_DEC = 20'b0_0_00_0_0_0_0_0_0_10_10_00_1_0_00;
  localparam logic [19:0] O_EXR = 20'b0_0_00_0_0_0_0_0_0_01_00_10_1_0_00;
  localparam logic [19:0] O_EXI = 20'b0_0_00_0_0_0_0_0_0_01_10_00_1_0_00;
  localparam logic [19:0] O_WBA = 20'b0_0_00_0_0_0_0_0_1_00_00_00_1_0_00;
  localparam logic [19:0] O_MRD = 20'b0_0_00_0_1_1_0_0_0_00_00_00_1_0_00;
  localparam logic [19:0] O_WBM = 20'b0_0_00_0_0_0_0_1_1_00_00_00_1_0_00;
  localparam logic [19:0] O_MWR = 20'b0_0_00_0_1_0_1_0_0_00_00_00_1_0_00;
  localparam logic [19:0] O_BR  = 20'b0_1_01_0_0_0_0_0_0_01_00_01_1_0_00;
  localparam logic [19:0] O_JMP = 20'b1_0_01_0_0_0_0_0_0_00_00_00_1_0_00;
  localparam logic [19:0] O_TR1 = 20'b0_0_00_0_0_0_0_0_0_00_00_00_0_1_01;
  localparam logic [19:0] O_TR2 = 20'b0_0_00_0_0_0_0_0_0_00_00_00_0_1_10;

  localparam logic [6:0] R  = 7'b0110011;
  localparam logic [6:0] I  = 7'b0010011;
  localparam logic [6:0] LD = 7'b0000011;
  localparam logic [6:0] SW = 7'b0100011;
  localparam logic [6:0] BQ = 7'b1100011;
  localparam logic [6:0] JL = 7'b1101111;
  localparam logic [6:0] BAD = 7'b1111111;

  typedef struct {
    string      nm;
    logic       rst_n, st, hl, rd;
    logic [6:0] op;
    logic [19:0] exp;
    logic [3:0] ret;
  } vec_t;

  vec_t tbl[$];
  int total = 0;
  int bad = 0;

  task automatic add(input string nm, input logic rs,
                     input logic st, input logic hl,
                     input logic rd, input logic [6:0] op,
                     input logic [19:0] exp,
                     input logic [3:0] ret);
    vec_t v;
    v.nm = nm; v.rst_n = rs; v.st = st; v.hl = hl;
    v.rd = rd; v.op = op; v.exp = exp; v.ret = ret;
    tbl.push_back(v);
  endtask

  // Drive one cycle's inputs, check, then advance past the edge.
  task automatic step(input string nm, input logic rs,
                      input logic st, input logic hl,
                      input logic rd, input logic [6:0] op,
                      input logic [19:0] exp,
                      input logic [3:0] ret);
    arst_n = rs; start = st; halt_req = hl;
    mem_ready = rd; opcode = op;
    #1;
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s outputs got=%b want=%b", nm, got, exp);
    end
    total++;
    if (retired !== ret) begin
      bad++;
      $display("FAIL %s retired got=%0d want=%0d",
               nm, retired, ret);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    // R-type, ready tied high, halt at retirement
    add("r_idle",  1, 0, 0, 1, R,  O_IDLE, 0);
    add("r_start", 1, 1, 0, 1, R,  O_IDLE, 0);
    add("r_fetch", 1, 0, 0, 1, R,  O_FR,   0);
    add("r_dec",   1, 0, 0, 1, R,  O_DEC,  0);
    add("r_exec",  1, 0, 0, 1, R,  O_EXR,  0);
    add("r_wb",    1, 0, 1, 1, R,  O_WBA,  0);
    add("r_done",  1, 0, 0, 1, R,  O_IDLE, 1);
    // load with three wait cycles in MEM_RD
    add("ld_start",1, 1, 0, 1, LD, O_IDLE, 1);
    add("ld_fetch",1, 0, 0, 1, LD, O_FR,   1);
    add("ld_dec",  1, 0, 0, 1, LD, O_DEC,  1);
    add("ld_addr", 1, 0, 0, 1, LD, O_EXI,  1);
    add("ld_mrd0", 1, 0, 0, 0, LD, O_MRD,  1);
    add("ld_mrd1", 1, 0, 0, 0, LD, O_MRD,  1);
    add("ld_mrd2", 1, 0, 0, 0, LD, O_MRD,  1);
    add("ld_mrd3", 1, 0, 0, 1, LD, O_MRD,  1);
    add("ld_wb",   1, 0, 1, 1, LD, O_WBM,  1);
    add("ld_done", 1, 0, 0, 1, LD, O_IDLE, 2);
    // beq, jal, sw stream; halt only honoured at sw retire
    add("bq_start",1, 1, 0, 1, BQ, O_IDLE, 2);
    add("bq_fetch",1, 0, 0, 1, BQ, O_FR,   2);
    add("bq_dec",  1, 0, 0, 1, BQ, O_DEC,  2);
    add("bq_br",   1, 1, 0, 1, BQ, O_BR,   2);
    add("jl_fetch",1, 0, 0, 1, JL, O_FR,   3);
    add("jl_dec",  1, 1, 0, 1, JL, O_DEC,  3);
    add("jl_jmp",  1, 0, 0, 1, JL, O_JMP,  3);
    add("sw_fetch",1, 0, 0, 1, SW, O_FR,   4);
    add("sw_dec",  1, 0, 0, 1, SW, O_DEC,  4);
    add("sw_addr", 1, 0, 1, 1, SW, O_EXI,  4);
    add("sw_wait", 1, 0, 1, 0, SW, O_MWR,  4);
    add("sw_ret",  1, 0, 1, 1, SW, O_MWR,  4);
    add("sw_done", 1, 0, 0, 1, SW, O_IDLE, 5);
    // illegal opcode, start ignored in TRAP, reset clears
    add("il_start",1, 1, 0, 1, BAD, O_IDLE, 5);
    add("il_fetch",1, 0, 0, 1, BAD, O_FR,   5);
    add("il_dec",  1, 0, 0, 1, BAD, O_DEC,  5);
    add("il_trap", 1, 1, 0, 1, BAD, O_TR1,  5);
    add("il_hold", 1, 0, 0, 1, BAD, O_TR1,  5);
    add("il_rst",  0, 0, 0, 1, BAD, O_TR1,  5);
    add("il_clr",  1, 0, 0, 1, R,   O_IDLE, 0);

    arst_n = 1'b0; start = 1'b0; halt_req = 1'b0;
    mem_ready = 1'b0; opcode = 7'd0;
    repeat (2) @(posedge clk);
    #1;

    foreach (tbl[k])
      step(tbl[k].nm, tbl[k].rst_n, tbl[k].st, tbl[k].hl,
           tbl[k].rd, tbl[k].op, tbl[k].exp, tbl[k].ret);

    // fetch timeout: four idle cycles trap with cause 10
    step("to_start", 1, 1, 0, 0, R, O_IDLE, 0);
    for (int i = 0; i < 4; i++)
      step("to_wait", 1, 0, 0, 0, R, O_FW, 0);
    step("to_trap", 1, 1, 0, 0, R, O_TR2, 0);
    step("to_rst",  0, 0, 0, 0, R, O_TR2, 0);
    step("to_clr",  1, 0, 0, 0, R, O_IDLE, 0);

    // ready on the last allowed cycle wins over the timeout
    step("tl_start", 1, 1, 0, 0, R, O_IDLE, 0);
    for (int i = 0; i < 3; i++)
      step("tl_wait", 1, 0, 0, 0, R, O_FW, 0);
    step("tl_ready", 1, 0, 0, 1, R, O_FR,  0);
    step("tl_dec",   1, 0, 0, 1, R, O_DEC, 0);
    step("tl_exec",  1, 0, 0, 1, R, O_EXR, 0);
    step("tl_wb",    1, 0, 1, 1, R, O_WBA, 0);
    step("tl_done",  1, 0, 0, 1, R, O_IDLE, 1);
    step("tl_rst",   0, 0, 0, 1, R, O_IDLE, 1);

    // sixteen I-type instructions wrap the 4-bit counter
    step("w_start", 1, 1, 0, 1, I, O_IDLE, 0);
    for (int i = 0; i < 16; i++) begin
      step("w_fetch", 1, 0, 0, 1, I, O_FR,  4'(i));
      step("w_dec",   1, 0, 0, 1, I, O_DEC, 4'(i));
      step("w_exec",  1, 0, 0, 1, I, O_EXI, 4'(i));
      step("w_wb",    1, 0, (i == 15), 1, I, O_WBA, 4'(i));
    end
    step("w_wrap", 1, 0, 0, 1, I, O_IDLE, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
